instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Converse of the control decoder: takes symbolic instruction requests (operation selector plus register, immediate and target fields) and encodes them into 32-bit MIPS words.
- Buffers the encoded words in a small FIFO.
- Streams them into instruction memory through a write port with a word-address counter.
- Used by the single-cycle CPU testbench/boot path to load programs without hex files.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- AW, 10, instruction-memory word-address width.
- BASE_ADDR, 0, first word address written after Start.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Start  in  1  pulse; begins a load session.
- InValid  in  1  request valid.
- InReady  out  1  request accepted when InValid&InReady.
- InLast  in  1  marks final request of session.
- OpSel  in  5  operation selector, values 0..20: add, addu, sub, subu, sll, srl, sra, jr, slt, and, or, ori, lw, sw, beq, bne, lui, j, jal, slti, addi.
- Rs, Rt, Rd, Shamt  in  5 each  register/shift fields.
- Imm  in  16  immediate or branch offset (used verbatim).
- Target  in  26  jump target field.
- ImWe  out  1  write request to instruction memory.
- ImReady  in  1  memory accepts write this cycle.
- ImAddr  out  AW  word address of current write.
- ImData  out  32  encoded instruction.
- Count  out  AW+1  words written this session.
- Busy  out  1  state is LOAD or DRAIN.
- Done  out  1  session complete.

Behaviour:
- Reset values (async rst): state IDLE, FIFO empty, InReady=0, ImWe=0, ImAddr=BASE_ADDR, ImData=0, Count=0, Busy=0, Done=0.
- States:
  - IDLE: Start → LOAD.
  - LOAD: an accepted request with InLast=1 → DRAIN.
  - DRAIN: FIFO empty and no write pending → DONE.
  - DONE: Start → LOAD.
- Start in IDLE or DONE: flush FIFO, ImAddr=BASE_ADDR, Count=0, Done=0. Start in LOAD or DRAIN is ignored.
- InReady = (state==LOAD) & FIFO not full. There is no lookahead: a full FIFO deasserts InReady even if a pop occurs in the same cycle.
- Encoding is combinational on the request. The word is pushed at the accepting edge.
- R-type words: op=0, funct add 0x20, addu 0x21, sub 0x22, subu 0x23, sll 0x00, srl 0x02, sra 0x03, jr 0x08, slt 0x2A, and 0x24, or 0x25.
- R-type field zeroing:
  - sll/srl/sra: rs=0.
  - jr: rt=rd=shamt=0.
  - All other R-types: shamt=0.
- I-type opcodes: ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, lui 0x0F (rs=0), slti 0x0A, addi 0x08. Layout: {op,Rs,Rt,Imm}.
- J-type opcodes: j 0x02, jal 0x03. Layout: {op,Target}.
- Write port:
  - ImWe=1 whenever the FIFO is non-empty. ImData and ImAddr come from the FIFO head and current address.
  - They must hold stable while ImWe&!ImReady.
  - On ImWe&ImReady: pop, ImAddr+1 (wraps modulo 2^AW silently), Count+1.
- Latency: a request accepted at edge N gives ImWe=1 in cycle N+1 if the FIFO was empty.
- Simultaneous push and pop on a non-full FIFO: both occur and occupancy is unchanged.
- Busy=1 in LOAD/DRAIN. Done=1 in DONE only.
- rst mid-session: all state is lost and the block returns to IDLE. A partially written program is not retried.

Optional Feature:
- Macro ENCODER_ILLEGAL_CHECK_EN.
- Defined: OpSel≥21 is accepted but not pushed; a sticky output IllegalOp (1 bit, reset 0, cleared on Start) is set. If InLast is on an illegal request, the session still moves to DRAIN.
- Undefined: no IllegalOp port; OpSel≥21 encodes as 0x00000000 (NOP) and is written normally.

Test Plan:
1. Start, then addi Rs=0 Rt=8 Imm=5 with InLast=1, ImReady=1 → ImData=0x20080005 at ImAddr=0; Count=1; Done=1 two cycles later.
2. add Rd=10 Rs=8 Rt=9; sll Rd=2 Rt=1 Shamt=4 Rs=7; lw Rt=9 Rs=29 Imm=4; j Target=0x10 → 0x01095020, 0x00011100, 0x8FA90004, 0x08000010 at addresses 0..3.
3. ImReady=0, push 5 requests with DEPTH=4 → InReady drops after 4th accept, ImData holds 1st word; raise ImReady → all 5 written in order, Count=5.
4. BASE_ADDR=1022, AW=10, 3 words → addresses 1022, 1023, 0.
5. Assert rst while 2 words are queued in DRAIN → next cycle ImWe=0, Busy=0, Count=0, ImAddr=BASE_ADDR; Start while Busy=1 has no effect.
6. OpSel=25 → with ENCODER_ILLEGAL_CHECK_EN: no write, IllegalOp=1; without it: 0x00000000 written.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic instruction requests into 32-bit MIPS words,
// queues them in a small FIFO and streams them into instruction memory
// through a write port with a word-address counter.
// Optional build macro: ENCODER_ILLEGAL_CHECK_EN. When it is defined,
// OpSel values above 20 are dropped and reported on a sticky IllegalOp output.
// When it is undefined, those values are written as a NOP.
module instr_encoder #(
   parameter int          DEPTH     = 4,
   parameter int          AW        = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          Start,
   input  logic          InValid,
   output logic          InReady,
   input  logic          InLast,
   input  logic [4:0]    OpSel,
   input  logic [4:0]    Rs,
   input  logic [4:0]    Rt,
   input  logic [4:0]    Rd,
   input  logic [4:0]    Shamt,
   input  logic [15:0]   Imm,
   input  logic [25:0]   Target,
   output logic          ImWe,
   input  logic          ImReady,
   output logic [AW-1:0] ImAddr,
   output logic [31:0]   ImData,
   output logic [AW:0]   Count,
`ifdef ENCODER_ILLEGAL_CHECK_EN
   output logic          IllegalOp,
`endif
   output logic          Busy,
   output logic          Done
);

   localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0]   LP_FULL = (PW+1)'(DEPTH);
   localparam logic [AW-1:0] LP_BASE = AW'(BASE_ADDR);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic [31:0]      r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_occ;
   logic [AW-1:0]    r_addr;
   logic [AW:0]      r_count;

   logic             w_empty;
   logic             w_full;
   logic             w_start;
   logic             w_accept;
   logic             w_legal;
   logic             w_push;
   logic             w_pop;
   logic [31:0]      w_word;

   // R-type word: {op=0, rs, rt, rd, shamt, funct}
   function automatic logic [31:0] f_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   // I-type word: {op, rs, rt, imm}
   function automatic logic [31:0] f_itype(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   assign w_empty  = (r_occ == '0);
   assign w_full   = (r_occ == LP_FULL);
   assign w_start  = Start & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign InReady  = (r_state == S_LOAD) & ~w_full;
   assign w_accept = InValid & InReady;
   assign w_push   = w_accept & w_legal;
   assign ImWe     = ~w_empty;
   assign w_pop    = ImWe & ImReady;

`ifdef ENCODER_ILLEGAL_CHECK_EN
   assign w_legal = (OpSel <= 5'd20);
`else
   assign w_legal = 1'b1;
`endif

   // Combinational encoder: operation selector plus fields to a MIPS word
   always_comb begin
      w_word = 32'h0000_0000;
      case (OpSel)
         5'd0:  w_word = f_rtype(Rs, Rt, Rd, 5'd0, 6'h20);          // add
         5'd1:  w_word = f_rtype(Rs, Rt, Rd, 5'd0, 6'h21);          // addu
         5'd2:  w_word = f_rtype(Rs, Rt, Rd, 5'd0, 6'h22);          // sub
         5'd3:  w_word = f_rtype(Rs, Rt, Rd, 5'd0, 6'h23);          // subu
         5'd4:  w_word = f_rtype(5'd0, Rt, Rd, Shamt, 6'h00);       // sll
         5'd5:  w_word = f_rtype(5'd0, Rt, Rd, Shamt, 6'h02);       // srl
         5'd6:  w_word = f_rtype(5'd0, Rt, Rd, Shamt, 6'h03);       // sra
         5'd7:  w_word = f_rtype(Rs, 5'd0, 5'd0, 5'd0, 6'h08);      // jr
         5'd8:  w_word = f_rtype(Rs, Rt, Rd, 5'd0, 6'h2A);          // slt
         5'd9:  w_word = f_rtype(Rs, Rt, Rd, 5'd0, 6'h24);          // and
         5'd10: w_word = f_rtype(Rs, Rt, Rd, 5'd0, 6'h25);          // or
         5'd11: w_word = f_itype(6'h0D, Rs, Rt, Imm);               // ori
         5'd12: w_word = f_itype(6'h23, Rs, Rt, Imm);               // lw
         5'd13: w_word = f_itype(6'h2B, Rs, Rt, Imm);               // sw
         5'd14: w_word = f_itype(6'h04, Rs, Rt, Imm);               // beq
         5'd15: w_word = f_itype(6'h05, Rs, Rt, Imm);               // bne
         5'd16: w_word = f_itype(6'h0F, 5'd0, Rt, Imm);             // lui
         5'd17: w_word = {6'h02, Target};                           // j
         5'd18: w_word = {6'h03, Target};                           // jal
         5'd19: w_word = f_itype(6'h0A, Rs, Rt, Imm);               // slti
         5'd20: w_word = f_itype(6'h08, Rs, Rt, Imm);               // addi
         default: w_word = 32'h0000_0000;                           // NOP
      endcase
   end

   // FIFO storage: written at the accepting edge, no reset needed
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_word;
      end
   end

   // FIFO pointers/occupancy plus write address and session word count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         r_addr   <= LP_BASE;
         r_count  <= '0;
      end else if (w_start) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         r_addr   <= LP_BASE;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_addr   <= r_addr + 1'b1;   // wraps modulo 2^AW
            r_count  <= r_count + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Session FSM with registered Busy/Done flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (Start) begin
                  r_state <= S_LOAD;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            S_LOAD: begin
               if (w_accept & InLast) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // the FIFO head is the only pending write, so empty means finished
               if (w_empty) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ENCODER_ILLEGAL_CHECK_EN
   logic r_illegal;

   // Sticky flag for dropped out-of-range selectors, cleared by a new session
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_illegal <= 1'b0;
      end else if (w_start) begin
         r_illegal <= 1'b0;
      end else if (w_accept & ~w_legal) begin
         r_illegal <= 1'b1;
      end
   end

   assign IllegalOp = r_illegal;
`endif

   // Head word is forced to zero when nothing is queued
   assign ImData = w_empty ? 32'h0000_0000 : r_mem[r_rd_ptr];
   assign ImAddr = r_addr;
   assign Count  = r_count;
   assign Busy   = r_busy;
   assign Done   = r_done;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a table of encoded-instruction vectors
// plus hand-written sequences for backpressure, reset and wrap cases.
// A second instance with BASE_ADDR=1022 shares all inputs to check wrapping.
module tb_instr_encoder;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          Start, InValid, InLast, ImReady;
   logic [4:0]    OpSel, Rs, Rt, Rd, Shamt;
   logic [15:0]   Imm;
   logic [25:0]   Target;
   logic          InReady, ImWe, Busy, Done;
   logic [AW-1:0] ImAddr;
   logic [31:0]   ImData;
   logic [AW:0]   Count;
   logic          InReady_b, ImWe_b, Busy_b, Done_b;
   logic [AW-1:0] ImAddr_b;
   logic [31:0]   ImData_b;
   logic [AW:0]   Count_b;
`ifdef ENCODER_ILLEGAL_CHECK_EN
   logic          IllegalOp, IllegalOp_b;
`endif

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(4), .AW(AW), .BASE_ADDR(0)) u_dut (
      .clk(clk), .rst(rst), .Start(Start), .InValid(InValid), .InReady(InReady),
      .InLast(InLast), .OpSel(OpSel), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt),
      .Imm(Imm), .Target(Target), .ImWe(ImWe), .ImReady(ImReady), .ImAddr(ImAddr),
      .ImData(ImData), .Count(Count),
`ifdef ENCODER_ILLEGAL_CHECK_EN
      .IllegalOp(IllegalOp),
`endif
      .Busy(Busy), .Done(Done)
   );

   instr_encoder #(.DEPTH(4), .AW(AW), .BASE_ADDR(1022)) u_dut_b (
      .clk(clk), .rst(rst), .Start(Start), .InValid(InValid), .InReady(InReady_b),
      .InLast(InLast), .OpSel(OpSel), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt),
      .Imm(Imm), .Target(Target), .ImWe(ImWe_b), .ImReady(ImReady), .ImAddr(ImAddr_b),
      .ImData(ImData_b), .Count(Count_b),
`ifdef ENCODER_ILLEGAL_CHECK_EN
      .IllegalOp(IllegalOp_b),
`endif
      .Busy(Busy_b), .Done(Done_b)
   );

   typedef struct {
      logic [4:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sh;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [21];

   int n_cmp = 0;
   int n_bad = 0;
   int base_a, base_b;

   logic [AW-1:0] q_addr[$];
   logic [31:0]   q_data[$];
   logic [AW-1:0] q_addr_b[$];
   logic [31:0]   q_data_b[$];

   // Record every write the memory accepts, sampled mid-cycle
   always @(negedge clk) begin
      if (ImWe && ImReady) begin
         q_addr.push_back(ImAddr);
         q_data.push_back(ImData);
      end
      if (ImWe_b && ImReady) begin
         q_addr_b.push_back(ImAddr_b);
         q_data_b.push_back(ImData_b);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_session();
      base_a = q_data.size();
      base_b = q_data_b.size();
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   task automatic send(input vec_t v, input logic last);
      int k;
      OpSel = v.op; Rs = v.rs; Rt = v.rt; Rd = v.rd; Shamt = v.sh;
      Imm = v.imm; Target = v.tgt;
      InValid = 1'b1;
      InLast  = last;
      k = 0;
      while (!InReady && k < 200) begin
         tick();
         k++;
      end
      if (!InReady) check("send_timeout", 32'(InReady), 32'd1);
      tick();
      InValid = 1'b0;
      InLast  = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (!Done && k < 300) begin
         tick();
         k++;
      end
      check("done", 32'(Done), 32'd1);
      check("done_b", 32'(Done_b), 32'd1);
   endtask

   task automatic compare_session(input int first, input int n);
      check("n_writes", 32'(q_data.size() - base_a), 32'(n));
      check("n_writes_b", 32'(q_data_b.size() - base_b), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (base_a + i < q_data.size()) begin
            $display("word %0d: addr %0d data 0x%08h", i, q_addr[base_a+i], q_data[base_a+i]);
            check("data", q_data[base_a+i], vecs[first+i].exp);
            check("addr", 32'(q_addr[base_a+i]), 32'(i));
         end
         if (base_b + i < q_data_b.size()) begin
            check("data_b", q_data_b[base_b+i], vecs[first+i].exp);
            check("addr_b", 32'(q_addr_b[base_b+i]), 32'((1022 + i) % 1024));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      //          op     rs     rt     rd     sh     imm        tgt           expected
      vecs[0]  = '{5'd0,  5'd8,  5'd9,  5'd10, 5'd0,  16'h0000, 26'h0,        32'h01095020}; // add
      vecs[1]  = '{5'd4,  5'd7,  5'd1,  5'd2,  5'd4,  16'h0000, 26'h0,        32'h00011100}; // sll
      vecs[2]  = '{5'd12, 5'd29, 5'd9,  5'd31, 5'd31, 16'h0004, 26'h3FFFFFF,  32'h8FA90004}; // lw
      vecs[3]  = '{5'd17, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010,  32'h08000010}; // j
      vecs[4]  = '{5'd1,  5'd1,  5'd2,  5'd3,  5'd5,  16'h0000, 26'h0,        32'h00221821}; // addu
      vecs[5]  = '{5'd2,  5'd4,  5'd5,  5'd6,  5'd0,  16'h0000, 26'h0,        32'h00853022}; // sub
      vecs[6]  = '{5'd3,  5'd31, 5'd31, 5'd31, 5'd0,  16'h0000, 26'h0,        32'h03FFF823}; // subu
      vecs[7]  = '{5'd5,  5'd9,  5'd4,  5'd3,  5'd31, 16'h0000, 26'h0,        32'h00041FC2}; // srl
      vecs[8]  = '{5'd6,  5'd0,  5'd6,  5'd5,  5'd2,  16'h0000, 26'h0,        32'h00062883}; // sra
      vecs[9]  = '{5'd7,  5'd31, 5'd5,  5'd6,  5'd7,  16'h0000, 26'h0,        32'h03E00008}; // jr
      vecs[10] = '{5'd8,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 26'h0,        32'h0022182A}; // slt
      vecs[11] = '{5'd9,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 26'h0,        32'h00221824}; // and
      vecs[12] = '{5'd10, 5'd1,  5'd2,  5'd3,  5'd9,  16'h0000, 26'h0,        32'h00221825}; // or
      vecs[13] = '{5'd11, 5'd8,  5'd9,  5'd17, 5'd3,  16'hFFFF, 26'h0,        32'h3509FFFF}; // ori
      vecs[14] = '{5'd13, 5'd29, 5'd31, 5'd0,  5'd0,  16'h0008, 26'h0,        32'hAFBF0008}; // sw
      vecs[15] = '{5'd14, 5'd1,  5'd2,  5'd0,  5'd0,  16'hFFFE, 26'h0,        32'h1022FFFE}; // beq
      vecs[16] = '{5'd15, 5'd3,  5'd0,  5'd0,  5'd0,  16'h0003, 26'h0,        32'h14600003}; // bne
      vecs[17] = '{5'd16, 5'd5,  5'd7,  5'd1,  5'd1,  16'h1234, 26'h0,        32'h3C071234}; // lui
      vecs[18] = '{5'd18, 5'd1,  5'd1,  5'd1,  5'd1,  16'h0000, 26'h3FFFFFF,  32'h0FFFFFFF}; // jal
      vecs[19] = '{5'd19, 5'd2,  5'd3,  5'd0,  5'd0,  16'h8000, 26'h0,        32'h28438000}; // slti
      vecs[20] = '{5'd20, 5'd0,  5'd8,  5'd0,  5'd0,  16'h0005, 26'h0,        32'h20080005}; // addi

      rst = 1'b1; Start = 1'b0; InValid = 1'b0; InLast = 1'b0; ImReady = 1'b0;
      OpSel = '0; Rs = '0; Rt = '0; Rd = '0; Shamt = '0; Imm = '0; Target = '0;
      tick();
      tick();
      check("rst_InReady", 32'(InReady), 32'd0);
      check("rst_ImWe", 32'(ImWe), 32'd0);
      check("rst_ImAddr", 32'(ImAddr), 32'd0);
      check("rst_ImData", ImData, 32'd0);
      check("rst_Count", 32'(Count), 32'd0);
      check("rst_Busy", 32'(Busy), 32'd0);
      check("rst_Done", 32'(Done), 32'd0);
      check("rst_ImAddr_b", 32'(ImAddr_b), 32'd1022);
      check("rst_Busy_b", 32'(Busy_b), 32'd0);
      check("rst_InReady_b", 32'(InReady_b), 32'd0);
      rst = 1'b0;
      tick();

      // single addi: latency, Count and Done timing
      ImReady = 1'b1;
      start_session();
      check("t1_Busy", 32'(Busy), 32'd1);
      check("t1_InReady", 32'(InReady), 32'd1);
      send(vecs[20], 1'b1);
      check("t1_ImWe", 32'(ImWe), 32'd1);
      check("t1_ImData", ImData, 32'h20080005);
      check("t1_ImAddr", 32'(ImAddr), 32'd0);
      check("t1_ImAddr_b", 32'(ImAddr_b), 32'd1022);
      tick();
      check("t1_Done_early", 32'(Done), 32'd0);
      check("t1_Count", 32'(Count), 32'd1);
      tick();
      check("t1_Done", 32'(Done), 32'd1);
      check("t1_Busy_end", 32'(Busy), 32'd0);
      compare_session(20, 1);

      // full table with streaming writes; B wraps 1022,1023,0,...
      start_session();
      for (int i = 0; i < 20; i++) send(vecs[i], (i == 19));
      wait_done();
      check("t2_Count", 32'(Count), 32'd20);
      check("t2_Count_b", 32'(Count_b), 32'd20);
      compare_session(0, 20);

      // backpressure: FIFO fills, head word holds
      ImReady = 1'b0;
      start_session();
      for (int i = 0; i < 4; i++) send(vecs[i], 1'b0);
      check("t3_InReady_full", 32'(InReady), 32'd0);
      check("t3_ImWe", 32'(ImWe), 32'd1);
      check("t3_ImData", ImData, vecs[0].exp);
      check("t3_ImAddr", 32'(ImAddr), 32'd0);
      tick();
      tick();
      check("t3_ImData_hold", ImData, vecs[0].exp);
      check("t3_ImAddr_hold", 32'(ImAddr), 32'd0);
      check("t3_InReady_hold", 32'(InReady), 32'd0);
      ImReady = 1'b1;
      send(vecs[4], 1'b1);
      wait_done();
      check("t3_Count", 32'(Count), 32'd5);
      compare_session(0, 5);

      // reset in DRAIN with two words queued; Start while busy is ignored
      ImReady = 1'b0;
      start_session();
      send(vecs[0], 1'b0);
      send(vecs[1], 1'b0);
      send(vecs[2], 1'b1);
      check("t5_Busy", 32'(Busy), 32'd1);
      ImReady = 1'b1;
      tick();
      ImReady = 1'b0;
      check("t5_Count1", 32'(Count), 32'd1);
      check("t5_ImAddr1", 32'(ImAddr), 32'd1);
      check("t5_ImData1", ImData, vecs[1].exp);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      check("t5_ign_InReady", 32'(InReady), 32'd0);
      check("t5_ign_ImWe", 32'(ImWe), 32'd1);
      check("t5_ign_Count", 32'(Count), 32'd1);
      check("t5_ign_Busy", 32'(Busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t5_rst_ImWe", 32'(ImWe), 32'd0);
      check("t5_rst_Busy", 32'(Busy), 32'd0);
      check("t5_rst_Count", 32'(Count), 32'd0);
      check("t5_rst_ImAddr", 32'(ImAddr), 32'd0);
      check("t5_rst_ImAddr_b", 32'(ImAddr_b), 32'd1022);
      check("t5_rst_ImData", ImData, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("t5_post_Busy", 32'(Busy), 32'd0);
      check("t5_post_ImWe", 32'(ImWe), 32'd0);
      check("t5_post_Done", 32'(Done), 32'd0);

      // out-of-range selector
      ImReady = 1'b1;
      start_session();
      v = '{5'd25, 5'd3, 5'd4, 5'd5, 5'd6, 16'h1111, 26'h2222, 32'h0};
      send(v, 1'b1);
      wait_done();
`ifdef ENCODER_ILLEGAL_CHECK_EN
      check("t6_n_writes", 32'(q_data.size() - base_a), 32'd0);
      check("t6_IllegalOp", 32'(IllegalOp), 32'd1);
      check("t6_Count", 32'(Count), 32'd0);
      start_session();
      check("t6_IllegalOp_clr", 32'(IllegalOp), 32'd0);
      check("t6_IllegalOp_b_clr", 32'(IllegalOp_b), 32'd0);
`else
      check("t6_n_writes", 32'(q_data.size() - base_a), 32'd1);
      if (base_a < q_data.size()) begin
         $display("word 0: addr %0d data 0x%08h", q_addr[base_a], q_data[base_a]);
         check("t6_nop", q_data[base_a], 32'h0000_0000);
      end
      check("t6_Count", 32'(Count), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
